// File: rtl/prng_arbiter.sv
// Round-robin arbiter sharing one 16-bit Fibonacci LFSR between NUM_REQ requesters.
// Each grant stirs the LFSR STIR_CYCLES steps, then presents one mixed byte until ack.
module prng_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int STIR_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               seed_load,
  input  logic [15:0]        seed_data,
  output logic               seed_ready,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] ack,
  output logic [NUM_REQ-1:0] gnt,
  output logic               rnd_valid,
  output logic [7:0]         rnd_data,
  output logic               busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [15:0] LFSR_INIT = 16'hACE1;

  typedef enum logic [1:0] {IDLE, STIR, PRESENT} state_e;

  state_e             state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               rnd_valid_q, rnd_valid_d;
  logic [7:0]         rnd_data_q, rnd_data_d;

  logic               found;
  logic [IW-1:0]      sel;
  logic [IW-1:0]      ptr_next;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
  endfunction

  function automatic logic [7:0] mix(input logic [15:0] s);
    return {s[14:8], s[15]} ^ {s[0], s[7:1]};
  endfunction

  // Scan starting at the pointer so the last-served requester gets lowest priority.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int idx;
      idx = (int'(ptr_q) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = IW'(idx);
      end
    end
  end

  assign ptr_next = IW'((int'(gidx_q) + 1) % NUM_REQ);

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        if (seed_load) begin
          lfsr_d = (seed_data == 16'h0000) ? LFSR_INIT : seed_data;
        end else if (found) begin
          gnt_d   = NUM_REQ'(1) << sel;
          gidx_d  = sel;
          cnt_d   = 8'(STIR_CYCLES - 1);
          state_d = STIR;
        end
      end
      STIR: begin
        lfsr_d = lfsr_step(lfsr_q);
        if (!req[gidx_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = ptr_next;
        end else if (cnt_q == 8'd0) begin
          state_d = PRESENT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      PRESENT: begin
        if (ack[gidx_q] || !req[gidx_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = ptr_next;
        end
      end
      default: state_d = IDLE;
    endcase
    rnd_valid_d = (state_d == PRESENT);
    rnd_data_d  = rnd_valid_d ? mix(lfsr_d) : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lfsr_q      <= LFSR_INIT;
      ptr_q       <= '0;
      gidx_q      <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      rnd_valid_q <= 1'b0;
      rnd_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      ptr_q       <= ptr_d;
      gidx_q      <= gidx_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      rnd_valid_q <= rnd_valid_d;
      rnd_data_q  <= rnd_data_d;
    end
  end

  assign gnt        = gnt_q;
  assign rnd_valid  = rnd_valid_q;
  assign rnd_data   = rnd_data_q;
  assign busy       = (state_q != IDLE);
  assign seed_ready = (state_q == IDLE);
endmodule

// File: tb/tb_prng_arbiter.sv
// Directed bench: stimulus pushes expected {gnt, byte} into a queue; a monitor
// pops one entry on each rising rnd_valid and compares.
module tb_prng_arbiter;
  localparam int STIR_A = 1;
  localparam int STIR_B = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       seed_load, seed_load_b;
  logic [15:0] seed_data, seed_data_b;
  logic [3:0] req, ack, req_b, ack_b;
  logic [3:0] gnt, gnt_b;
  logic       seed_ready, seed_ready_b, rnd_valid, rnd_valid_b, busy, busy_b;
  logic [7:0] rnd_data, rnd_data_b;

  always #5 clk = ~clk;

  prng_arbiter #(.NUM_REQ(4), .STIR_CYCLES(STIR_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_data(seed_data),
    .seed_ready(seed_ready), .req(req), .ack(ack), .gnt(gnt),
    .rnd_valid(rnd_valid), .rnd_data(rnd_data), .busy(busy));

  prng_arbiter #(.NUM_REQ(4), .STIR_CYCLES(STIR_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load_b), .seed_data(seed_data_b),
    .seed_ready(seed_ready_b), .req(req_b), .ack(ack_b), .gnt(gnt_b),
    .rnd_valid(rnd_valid_b), .rnd_data(rnd_data_b), .busy(busy_b));

  typedef struct packed {logic [3:0] gnt; logic [7:0] data;} exp_t;
  exp_t sb_q[$];
  exp_t mon_e;
  bit   mon_seen = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [15:0] lfsr_m;

  function automatic logic [15:0] step_f(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
  endfunction

  function automatic logic [7:0] mix_f(input logic [15:0] s);
    logic [7:0] hi, lo;
    hi = s[15:8];
    lo = s[7:0];
    return {hi[6:0], hi[7]} ^ {lo[0], lo[7:1]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Advance the model by one draw and queue its expected result.
  task automatic push_exp(input int g, input logic [7:0] hand, input bit use_hand);
    exp_t e;
    for (int i = 0; i < STIR_A; i++) lfsr_m = step_f(lfsr_m);
    e.gnt  = 4'(1 << g);
    e.data = use_hand ? hand : mix_f(lfsr_m);
    sb_q.push_back(e);
  endtask

  task automatic wait_valid(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (rnd_valid) ok = 1'b1;
      else cyc();
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: rnd_valid timeout, got 0 expected 1", name);
    end
  endtask

  task automatic draw(input int g, input logic [7:0] hand, input bit use_hand, input string name);
    push_exp(g, hand, use_hand);
    wait_valid(name);
    ack = 4'(1 << g);
    cyc();
    ack = 4'b0;
    chk({name, "_valid_clr"}, 32'(rnd_valid), 32'd0);
    chk({name, "_gnt_clr"}, 32'(gnt), 32'd0);
  endtask

  task automatic seed(input logic [15:0] v);
    seed_load = 1'b1;
    seed_data = v;
    cyc();
    seed_load = 1'b0;
    lfsr_m = (v == 16'h0000) ? 16'hACE1 : v;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rnd_valid && !mon_seen) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: got byte %0h expected none", rnd_data);
        end else begin
          mon_e = sb_q.pop_front();
          chk("sb_gnt", 32'(gnt), 32'(mon_e.gnt));
          chk("sb_data", 32'(rnd_data), 32'(mon_e.data));
        end
      end
      mon_seen = rnd_valid;
    end
  end

  initial begin
    logic [7:0] held;
    rst_n = 1'b0; seed_load = 1'b0; seed_data = '0; req = '0; ack = '0;
    seed_load_b = 1'b0; seed_data_b = '0; req_b = '0; ack_b = '0;
    for (int i = 0; i < 2; i++) begin
      req = 4'($urandom);
      ack = 4'($urandom);
      cyc();
    end
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_valid", 32'(rnd_valid), 32'd0);
    chk("rst_data", 32'(rnd_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_seed_ready", 32'(seed_ready), 32'd1);
    rst_n = 1'b1; req = '0; ack = '0;
    lfsr_m = 16'hACE1;
    cyc();

    req = 4'b0001; draw(0, 8'h00, 1'b0, "first_draw");
    seed(16'h0001); draw(0, 8'h01, 1'b1, "seed_0001");
    seed(16'h8000); draw(0, 8'h80, 1'b1, "seed_8000");
    seed(16'h0000); draw(0, 8'h00, 1'b0, "seed_0000");
    req = 4'b1000; draw(3, 8'h00, 1'b0, "ptr_to_0");

    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      draw(k % 4, 8'h00, 1'b0, "rr");
      if (k == 4) req = 4'b0000;
    end
    cyc();
    chk("rr_no_regrant", 32'(gnt), 32'd0);

    // seed_load wins over a simultaneous request
    seed_load = 1'b1; seed_data = 16'h1234; req = 4'b0100;
    cyc();
    seed_load = 1'b0; lfsr_m = 16'h1234;
    chk("simul_no_gnt", 32'(gnt), 32'd0);
    chk("simul_seed_ready", 32'(seed_ready), 32'd1);
    cyc();
    chk("simul_gnt2", 32'(gnt), 32'h4);
    chk("simul_busy", 32'(busy), 32'd1);
    push_exp(2, 8'h00, 1'b0);
    wait_valid("simul");
    held = mix_f(lfsr_m);
    ack = 4'b0010; seed_load = 1'b1; seed_data = 16'hFFFF;
    cyc();
    chk("foreign_ack_valid", 32'(rnd_valid), 32'd1);
    chk("foreign_ack_gnt", 32'(gnt), 32'h4);
    chk("present_seed_data", 32'(rnd_data), 32'(held));
    seed_load = 1'b0; ack = 4'b0100;
    cyc();
    ack = 4'b0; req = 4'b0;
    chk("simul_ack_valid", 32'(rnd_valid), 32'd0);

    // abandon during STIR; pointer moves past requester 3 to 0
    req = 4'b1000;
    cyc();
    chk("abandon_gnt3", 32'(gnt), 32'h8);
    req = 4'b0000;
    cyc();
    chk("abandon_gnt", 32'(gnt), 32'd0);
    chk("abandon_busy", 32'(busy), 32'd0);
    chk("abandon_valid", 32'(rnd_valid), 32'd0);
    req = 4'b1111;
    cyc();
    chk("abandon_ptr0", 32'(gnt), 32'h1);
    req = 4'b0000;
    cyc();
    chk("abandon2_busy", 32'(busy), 32'd0);

    // reset in PRESENT
    seed(16'h5A5A);
    req = 4'b0010;
    push_exp(1, 8'h00, 1'b0);
    wait_valid("midrst");
    rst_n = 1'b0;
    cyc();
    chk("midrst_gnt", 32'(gnt), 32'd0);
    chk("midrst_valid", 32'(rnd_valid), 32'd0);
    chk("midrst_data", 32'(rnd_data), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_seed_ready", 32'(seed_ready), 32'd1);
    rst_n = 1'b1; req = 4'b0; lfsr_m = 16'hACE1;
    cyc();
    req = 4'b0001; draw(0, 8'h00, 1'b0, "post_rst");
    req = 4'b0;

    // latency with a longer stir: seed 0x0001 stirred 3 steps is 0x0008 -> 0x04
    seed_load_b = 1'b1; seed_data_b = 16'h0001;
    cyc();
    seed_load_b = 1'b0; req_b = 4'b0010;
    cyc();
    chk("b_gnt", 32'(gnt_b), 32'h2);
    chk("b_valid_e0", 32'(rnd_valid_b), 32'd0);
    cyc();
    chk("b_valid_e1", 32'(rnd_valid_b), 32'd0);
    cyc();
    chk("b_valid_e2", 32'(rnd_valid_b), 32'd0);
    cyc();
    chk("b_valid_e3", 32'(rnd_valid_b), 32'd1);
    chk("b_data", 32'(rnd_data_b), 32'h04);
    ack_b = 4'b0010;
    cyc();
    ack_b = 4'b0; req_b = 4'b0;
    chk("b_ack_valid", 32'(rnd_valid_b), 32'd0);
    chk("b_ack_busy", 32'(busy_b), 32'd0);

    repeat (3) cyc();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/prng_arbiter.md
# prng_arbiter

Round-robin arbiter and sequencer that shares one 16-bit Fibonacci LFSR random-byte generator between `NUM_REQ` requesters. It owns the LFSR state, handles seed loading with lock-up protection, and advances the register a fixed number of steps per draw. Each grant delivers one mixed 8-bit value over a valid/ack handshake. It sits between the PRNG datapath and the consumer blocks in the tile.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `STIR_CYCLES`, default 8: LFSR steps per draw, 1..255.
- `clk`  in  1: single clock, all state updates on the rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `seed_load`  in  1: one-cycle pulse that loads `seed_data`. It is honoured only while `seed_ready` is 1.
- `seed_data`  in  16: new LFSR state.
- `seed_ready`  out  1: 1 while in IDLE.
- `req`  in  `NUM_REQ`: level request, one bit per requester.
- `ack`  in  `NUM_REQ`: consume strobe, one bit per requester.
- `gnt`  out  `NUM_REQ`: registered one-hot grant. It is all-zero when no transaction is active.
- `rnd_valid`  out  1: random byte is available to the granted requester.
- `rnd_data`  out  8: random byte. It is 0 whenever `rnd_valid` is 0.
- `busy`  out  1: 1 in STIR or PRESENT.

## Operation
- **LFSR step rule**
  - The register shifts left by one.
  - The new bit 0 is `s[15]^s[14]^s[12]^s[3]`.
- **Mix function**
  - `rnd_data = rotl1(s[15:8]) ^ rotr1(s[7:0])`.
  - Both rotates are 8-bit rotates by one position.
- **When the LFSR changes**
  - It steps only in STIR.
  - It is frozen in IDLE and PRESENT.
- **Reset (`rst_n`=0 at an edge)**
  - LFSR = 16'hACE1, state = IDLE, round-robin pointer = 0, stir counter = 0.
  - `gnt`=0, `rnd_valid`=0, `rnd_data`=0, `busy`=0, `seed_ready`=1.
  - Reset asserted mid-transaction abandons it. No ack is needed.
- **States**
  - IDLE → SEED action: if `seed_load` is 1, the LFSR is loaded with `seed_data`, and with 16'hACE1 if `seed_data`==0. State stays IDLE and no grant is issued that cycle. A seed load wins over a simultaneous `req`.
  - IDLE → STIR: if `seed_load` is 0 and `req`≠0, the arbiter grants the first asserted requester at or above the pointer, wrapping modulo `NUM_REQ`. It sets `gnt`, sets counter = `STIR_CYCLES`-1 and goes to STIR.
  - STIR: the LFSR steps every cycle. When counter==0 the state goes to PRESENT; otherwise the counter decrements. The total is exactly `STIR_CYCLES` steps.
  - PRESENT: `rnd_valid`=1 and `rnd_data`=mix(LFSR), with the LFSR held.
    - On `ack[g]` with `gnt[g]`=1: go to IDLE, clear `gnt`, pointer = (g+1) mod `NUM_REQ`.
  - Abandon, in STIR or PRESENT: if `req[g]` drops before ack, the state goes to IDLE next edge. `gnt` is cleared and the pointer advances as above. LFSR steps already taken are kept.
- **Ignored inputs**
  - `ack` bits of non-granted requesters are ignored.
  - `ack` outside PRESENT is ignored.
  - `seed_load` outside IDLE is dropped, not queued.
- **Fairness**
  - With all requests asserted, grants cycle 0,1,…,`NUM_REQ`-1,0.

## Timing
- Request sampled in IDLE at edge E0 → `gnt` and `busy` high after E0.
- `rnd_valid` rises after edge E0+`STIR_CYCLES`.
- Ack sampled at edge Ea → `rnd_valid`, `gnt` and `busy` low after Ea. IDLE lasts one cycle minimum.
- Back-to-back throughput: one byte per `STIR_CYCLES`+2 cycles, plus ack wait.
- Seed load: the new value is visible after the load edge. The earliest grant follows at the next edge.
- All outputs are registered or decoded from registered state. There is no combinational path from `req` or `ack` to any output.

## Test plan
- **Reset defaults:** hold `rst_n`=0 for 2 cycles with random `req`/`ack` → `gnt`=0, `rnd_valid`=0, `rnd_data`=0, `seed_ready`=1. LFSR = 16'hACE1, observed via the first draw matching the software model.
- **Seed 0x0001:** `STIR_CYCLES`=1, load 16'h0001, assert `req[0]` → `gnt`=4'b0001, `rnd_valid` 2 cycles after grant edge… precisely after edge E0+1, with `rnd_data`=8'h01. Ack → IDLE.
- **Seed 0x8000:** `STIR_CYCLES`=1, load 16'h8000, draw → `rnd_data`=8'h80. Load 16'h0000, draw → equals a draw from seed 16'hACE1.
- **Round robin:** `req`=4'b1111 held, ack each byte on the first valid cycle → grant order 0,1,2,3,0. The LFSR sequence matches the model across all 5 draws.
- **Simultaneous events:**
  - `seed_load` and `req[2]` in the same IDLE cycle → seed loaded and no grant that cycle; grant to 2 on the next edge.
  - `ack[1]` while `gnt[2]` → ignored; `rnd_valid` stays high.
- **Abandon and mid-reset:**
  - Drop `req[3]` during STIR → IDLE next edge, pointer = 0.
  - Assert `rst_n`=0 in PRESENT → all outputs at reset values after that edge.
  - Assert `seed_load` in PRESENT → no effect on `rnd_data`.
